// File: rtl/riscv_debug_ring_ext_arbiter.sv
// Packet-granular round-robin arbiter for a debug ring extension channel.
// Several sources share one channel. A grant is held from the first flit of a
// packet up to and including its last flit, so packets never interleave. The
// output is a single registered flit stage with a valid/ready handshake.
// Optional build macro RISCV_DBG_ARB_PKTCNT_EN adds per-source packet counters
// (pkt_cnt) and a synchronous clear input (pkt_cnt_clr).
module riscv_debug_ring_ext_arbiter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned PORTS = 4,
    localparam int unsigned PW   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS-1:0][XLEN-1:0] in_data,
    input  logic [PORTS-1:0]           in_last,
    input  logic [PORTS-1:0]           in_valid,
    output logic [PORTS-1:0]           in_ready,
    output logic [XLEN-1:0]            out_data,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PW-1:0]              grant_id,
    output logic                       busy
`ifdef RISCV_DBG_ARB_PKTCNT_EN
    ,
    input  logic                       pkt_cnt_clr,
    output logic [PORTS-1:0][15:0]     pkt_cnt
`endif
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   rr_sel;
    logic [PW-1:0]   rr_idx;
    logic            req_any;
    logic            out_free;
    logic            xfer;
    logic            xfer_last;

    logic [XLEN-1:0] out_data_q;
    logic            out_last_q;
    logic            out_valid_q;

    // Round-robin search: first requesting index starting at rr_ptr.
    always_comb begin
        rr_sel  = '0;
        rr_idx  = '0;
        req_any = 1'b0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            rr_idx = PW'((32'(rr_ptr_q) + k) % PORTS);
            if (!req_any && in_valid[rr_idx]) begin
                req_any = 1'b1;
                rr_sel  = rr_idx;
            end
        end
    end

    // The output stage can take a flit when empty or draining this cycle.
    assign out_free  = !out_valid_q || out_ready;
    assign xfer      = (state_q == StLocked) && in_valid[grant_q] && out_free;
    assign xfer_last = xfer && in_last[grant_q];

    // Only the locked source ever sees ready.
    always_comb begin
        in_ready = '0;
        if (state_q == StLocked) begin
            in_ready[grant_q] = out_free;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the last flit.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    grant_d = rr_sel;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (xfer_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_q == PW'(PORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Output flit register: load on transfer, clear valid when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_data_q  <= in_data[grant_q];
            out_last_q  <= in_last[grant_q];
            out_valid_q <= 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == StLocked);

`ifdef RISCV_DBG_ARB_PKTCNT_EN
    logic [PORTS-1:0][15:0] pkt_cnt_q;

    // Per-source completed-packet counters; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || pkt_cnt_clr) begin
            pkt_cnt_q <= '0;
        end else if (xfer_last) begin
            pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_debug_ring_ext_arbiter.sv
// Scoreboard bench for riscv_debug_ring_ext_arbiter. Sources hold queued
// packets; a packet-level round-robin model predicts the output flit order,
// and a monitor pops and compares each flit the DUT hands downstream.
module tb_riscv_debug_ring_ext_arbiter;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned PORTS = 4;
    localparam int unsigned PW    = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [PORTS-1:0][XLEN-1:0] in_data;
    logic [PORTS-1:0]           in_last;
    logic [PORTS-1:0]           in_valid;
    logic [PORTS-1:0]           in_ready;
    logic [XLEN-1:0]            out_data;
    logic                       out_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [PW-1:0]              grant_id;
    logic                       busy;
`ifdef RISCV_DBG_ARB_PKTCNT_EN
    logic                       pkt_cnt_clr;
    logic [PORTS-1:0][15:0]     pkt_cnt;
`endif

    always #5 clk = ~clk;

    riscv_debug_ring_ext_arbiter #(
        .XLEN  (XLEN),
        .PORTS (PORTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef RISCV_DBG_ARB_PKTCNT_EN
        ,
        .pkt_cnt_clr (pkt_cnt_clr),
        .pkt_cnt     (pkt_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [XLEN:0] exp_q[$];          // {last, data}
    logic [XLEN:0] src_q[PORTS][$];   // pending flits per source
    int            m_ptr   = 0;       // model round-robin pointer
    int            pkt_seq = 0;
    bit            mon_en  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int src, input int n, input logic [XLEN-1:0] base);
        logic [XLEN-1:0] d;
        for (int k = 0; k < n; k++) begin
            if (base != '0) d = base + XLEN'(k);
            else            d = {8'(src), 16'(pkt_seq), 8'(k), 32'($urandom)};
            src_q[src].push_back({(k == n - 1), d});
        end
        pkt_seq++;
    endtask

    // Whole packets leave in round-robin order over sources with packets left.
    task automatic model_fill();
        logic [XLEN:0] mq[PORTS][$];
        logic [XLEN:0] f;
        int s;
        for (int i = 0; i < PORTS; i++) mq[i] = src_q[i];
        while (1) begin
            s = -1;
            for (int k = 0; k < PORTS; k++)
                if (s < 0 && mq[(m_ptr + k) % PORTS].size() != 0) s = (m_ptr + k) % PORTS;
            if (s < 0) break;
            do begin
                f = mq[s].pop_front();
                exp_q.push_back(f);
            end while (!f[XLEN]);
            m_ptr = (s + 1) % PORTS;
        end
    endtask

    // Drive all queued packets; returns the cycle count until the last flit was taken.
    task automatic run(input int bub_pct, input int rdy_mode, input int hole_src,
                       input int hole_len, input bit clr_last, output int cyc);
        logic [PORTS-1:0] fire;
        bit               first[PORTS];
        int               hole_cnt;
        bit               hole_used;
        bit               empty;
        logic [XLEN:0]    f;
        fire      = '0;
        hole_cnt  = 0;
        hole_used = 1'b0;
        cyc       = 0;
        for (int i = 0; i < PORTS; i++) first[i] = 1'b1;
        model_fill();
        while (1) begin
            @(negedge clk);
`ifdef RISCV_DBG_ARB_PKTCNT_EN
            pkt_cnt_clr = 1'b0;
`endif
            for (int i = 0; i < PORTS; i++) begin
                if (fire[i]) begin
                    f = src_q[i].pop_front();
                    first[i] = f[XLEN];
                    if (i == hole_src && !hole_used && !f[XLEN]) begin
                        hole_cnt  = hole_len;
                        hole_used = 1'b1;
                    end
                end
            end
            empty = 1'b1;
            for (int i = 0; i < PORTS; i++) if (src_q[i].size() != 0) empty = 1'b0;
            if (empty) break;
            if (cyc >= 3000) begin
                chk("drive_timeout", 128'(cyc), 128'(0));
                for (int i = 0; i < PORTS; i++) src_q[i].delete();
                break;
            end
            cyc++;
            in_valid = '0;
            for (int i = 0; i < PORTS; i++) begin
                if (src_q[i].size() != 0) begin
                    f = src_q[i][0];
                    in_data[i] = f[XLEN-1:0];
                    in_last[i] = f[XLEN];
                    if (i == hole_src && hole_cnt > 0) begin
                        hole_cnt--;
                        chk("hold_grant", {busy, grant_id}, {1'b1, PW'(i)});
                    end else if (!first[i] && $urandom_range(99) < bub_pct) begin
                        chk("bubble_grant", {busy, grant_id}, {1'b1, PW'(i)});
                    end else begin
                        in_valid[i] = 1'b1;
                    end
                end
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 1);
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            fire = in_valid & in_ready;
`ifdef RISCV_DBG_ARB_PKTCNT_EN
            pkt_cnt_clr = clr_last && |(fire & in_last);
`endif
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Monitor: flit scoreboard, stall stability and ready gating.
    initial begin
        logic          prev_stall;
        logic [XLEN:0] prev_flit;
        prev_stall = 1'b0;
        prev_flit  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_flit});
                chk("in_ready_rule", in_ready,
                    (!busy || (out_valid && !out_ready)) ? '0 : (PORTS'(1) << grant_id));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_flit", 128'(1), 128'(0));
                    else chk("out_flit", {out_last, out_data}, exp_q.pop_front());
                end
                prev_stall = out_valid && !out_ready;
                prev_flit  = {out_last, out_data};
            end
        end
    end

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef RISCV_DBG_ARB_PKTCNT_EN
        pkt_cnt_clr = 1'b0;
`endif
        // Reset with every source requesting, then one idle cycle after it.
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant_id, 0);
            chk("rst_out_data", {out_last, out_data}, 0);
            if (r == 1) begin
                rst      = 1'b0;
                in_valid = '0;
            end
        end
        mon_en = 1'b1;

        // Round robin: two 2-flit packets per source, 3 cycles per packet.
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < PORTS; s++) add_pkt(s, 2, '0);
        run(0, 0, -1, 0, 1'b0, cyc);
        chk("rr_cycles", 128'(cyc), 128'(24));

        // Backpressure on a single 4-flit packet from source 2.
        add_pkt(2, 4, 64'hA0);
        run(0, 1, -1, 0, 1'b0, cyc);

        // Pointer now at 3: single-flit packet from 3, then 0 and 3 compete.
        add_pkt(3, 1, '0);
        run(0, 0, -1, 0, 1'b0, cyc);
        add_pkt(0, 1, '0);
        add_pkt(3, 1, '0);
        run(0, 0, -1, 0, 1'b0, cyc);

        // Source 1 stalls 5 cycles mid-packet while source 3 waits.
        do_reset();
        add_pkt(1, 3, '0);
        add_pkt(3, 2, '0);
        run(0, 0, 1, 5, 1'b0, cyc);

        // Random packet mixes with bubbles and random downstream ready.
        for (int r = 0; r < 20; r++) begin
            for (int s = 0; s < PORTS; s++) begin
                int np;
                np = int'($urandom_range(3));
                for (int p = 0; p < np; p++) add_pkt(s, int'($urandom_range(4, 1)), '0);
            end
            run(25, 2, -1, 0, 1'b0, cyc);
        end

`ifdef RISCV_DBG_ARB_PKTCNT_EN
        // Three counted packets, then a clear coinciding with a fourth last flit.
        do_reset();
        for (int p = 0; p < 3; p++) add_pkt(0, 2, '0);
        run(0, 0, -1, 0, 1'b0, cyc);
        chk("pkt_cnt_3", pkt_cnt[0], 3);
        add_pkt(0, 2, '0);
        run(0, 0, -1, 0, 1'b1, cyc);
        chk("pkt_cnt_clr", pkt_cnt[0], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
